// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package countdown_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD-style down-counting digit with parallel load; decrement wraps 0 -> BASE-1.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] din,
    input  logic               dec,
    output logic [DIGIT_W-1:0] dout,
    output logic               is_zero
);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = din;
        end else if (dec) begin
            digit_d = (digit_q == '0) ? DIGIT_W'(BASE - 1) : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign dout    = digit_q;
    assign is_zero = (digit_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: FSM, prescaler and borrow chain.
// Optional COUNTDOWN_AUTO_RELOAD_EN reloads the last load value on reaching zero.
module bcd_countdown_timer
    import countdown_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BASE       = 10,
    parameter int TICK_DIV   = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
    input  logic                          start,
    input  logic                          stop,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count_value,
    output logic                          running,
    output logic                          done,
    output logic                          expired
);

    localparam int CW         = NUM_DIGITS * DIGIT_W;
    localparam int PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ({1'b0, v[k*DIGIT_W +: DIGIT_W]} >= 5'(BASE)) begin
                r[k*DIGIT_W +: DIGIT_W] = DIGIT_W'(BASE - 1);
            end
        end
        return r;
    endfunction

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic            running_q, done_q, expired_q;

    logic [CW-1:0]         load_san;
    logic [CW-1:0]         digit_din;
    logic                  digit_load;
    logic                  reload;
    logic                  tick;
    logic                  count_zero;
    logic                  count_one;
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS:0]   lower_zero;
    logic [NUM_DIGITS-1:0] digit_dec;

    assign load_san   = sanitize(load_value);
    assign count_zero = lower_zero[NUM_DIGITS];
    assign count_one  = (count_value == CW'(1));

    // stop and load both pre-empt a pending tick
    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST) && !stop && !load;

    assign lower_zero[0] = 1'b1;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_chain
        assign lower_zero[k+1] = lower_zero[k] & digit_zero[k];
        assign digit_dec[k]    = tick & lower_zero[k];
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [CW-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (load) begin
            shadow_q <= load_san;
        end
    end

    assign reload     = tick && count_one && (shadow_q != '0);
    assign digit_load = load | reload;
    assign digit_din  = load ? load_san : shadow_q;
`else
    assign reload     = 1'b0;
    assign digit_load = load;
    assign digit_din  = load_san;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_down_digit #(
            .BASE(BASE)
        ) u_digit (
            .clk    (clk),
            .rst    (rst),
            .load   (digit_load),
            .din    (digit_din[k*DIGIT_W +: DIGIT_W]),
            .dec    (digit_dec[k]),
            .dout   (count_value[k*DIGIT_W +: DIGIT_W]),
            .is_zero(digit_zero[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                running_q <= 1'b0;
                expired_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_PAUSE: begin
                        if (state_q == ST_IDLE) begin
                            presc_q <= '0;
                        end
                        if (!stop && start && !count_zero) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            if (count_one) begin
                                done_q <= 1'b1;
                                if (!reload) begin
                                    state_q   <= ST_EXPIRED;
                                    running_q <= 1'b0;
                                    expired_q <= 1'b1;
                                end
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    default: begin
                        presc_q <= '0;
                    end
                endcase
            end
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized plus directed bench for bcd_countdown_timer against an integer-count reference model.
module tb_bcd_countdown_timer;

    localparam int ND   = 2;
    localparam int BASE = 10;
    localparam int TD   = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [ND*4-1:0]  load_value;
    logic             start;
    logic             stop;
    logic [ND*4-1:0]  count_value;
    logic             running;
    logic             done;
    logic             expired;

    bcd_countdown_timer #(
        .NUM_DIGITS(ND),
        .BASE      (BASE),
        .TICK_DIV  (TD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .count_value(count_value),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count kept as a plain integer, mode as a small code
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_mode, m_cnt, m_pre, m_shadow;
    bit m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sanit(input logic [ND*4-1:0] v);
        int n, pw, d;
        logic [ND*4-1:0] t;
        n  = 0;
        pw = 1;
        t  = v;
        for (int k = 0; k < ND; k++) begin
            d = int'(t[k*4 +: 4]);
            if (d > BASE - 1) d = BASE - 1;
            n  += d * pw;
            pw *= BASE;
        end
        return n;
    endfunction

    function automatic logic [ND*4-1:0] to_bcd(input int n);
        logic [ND*4-1:0] r;
        int x;
        x = n;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            r[k*4 +: 4] = 4'(x % BASE);
            x = x / BASE;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_shadow = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [ND*4-1:0] lv, input bit st, input bit sp);
        m_done = 1'b0;
        if (ld) begin
            m_cnt = sanit(lv); m_shadow = m_cnt; m_mode = M_IDLE; m_pre = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_PAUSE: if (!sp && st && m_cnt != 0) m_mode = M_RUN;
                M_RUN: begin
                    if (sp) m_mode = M_PAUSE;
                    else if (m_pre == TD - 1) begin
                        m_pre = 0;
                        m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin
                            m_done = 1'b1;
                            if (AUTO && m_shadow != 0) m_cnt = m_shadow;
                            else m_mode = M_EXP;
                        end
                    end else m_pre++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},   32'(count_value), 32'(to_bcd(m_cnt)));
        chk({tag, ".running"}, 32'(running),     32'(m_mode == M_RUN));
        chk({tag, ".done"},    32'(done),        32'(m_done));
        chk({tag, ".expired"}, 32'(expired),     32'(m_mode == M_EXP));
    endtask

    task automatic cycle(input string tag, input bit ld, input logic [ND*4-1:0] lv,
                         input bit st, input bit sp);
        @(negedge clk);
        load = ld; load_value = lv; start = st; stop = sp;
        @(posedge clk);
        model_step(ld, lv, st, sp);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset.count", 32'(count_value), 32'h0);
        chk("reset.flags", {29'd0, running, done, expired}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic countdown
        cycle("t1", 1'b1, 8'h12, 1'b0, 1'b0);
        cycle("t1", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (60) cycle("t1", 1'b0, 8'h00, 1'b0, 1'b0);

        // 2: borrow across digits
        cycle("t2", 1'b1, 8'h10, 1'b0, 1'b0);
        cycle("t2", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) cycle("t2", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2.borrow", 32'(count_value), 32'h09);
        repeat (40) cycle("t2", 1'b0, 8'h00, 1'b0, 1'b0);

        // 3: pause and resume
        cycle("t3", 1'b1, 8'h05, 1'b0, 1'b0);
        cycle("t3", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) cycle("t3", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("t3", 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) cycle("t3", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3.hold", 32'(count_value), 32'h04);
        cycle("t3", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (24) cycle("t3", 1'b0, 8'h00, 1'b0, 1'b0);

        // 4: priority and sanitising
        cycle("t4", 1'b1, 8'hAF, 1'b1, 1'b0);
        chk("t4.sanitise", 32'(count_value), 32'h99);
        chk("t4.idle", 32'(running), 32'h0);
        cycle("t4", 1'b1, 8'h00, 1'b0, 1'b0);
        cycle("t4", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) cycle("t4", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4.nodone", 32'(done), 32'h0);

        // 5: async reset mid-run
        cycle("t5", 1'b1, 8'h09, 1'b0, 1'b0);
        cycle("t5", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40 && m_cnt != 7; i++) cycle("t5", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5.reached7", 32'(count_value), 32'h07);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5.rst_count", 32'(count_value), 32'h0);
        chk("t5.rst_flags", {29'd0, running, done, expired}, 32'h0);
        model_reset();
        #1 rst = 1'b0;
        repeat (20) cycle("t5", 1'b0, 8'h00, 1'b0, 1'b0);

        // 6: auto-reload (plain expiry when the macro is undefined)
        cycle("t6", 1'b1, 8'h02, 1'b0, 1'b0);
        cycle("t6", 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (34) cycle("t6", 1'b0, 8'h00, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, sp;
            logic [ND*4-1:0] lv;
            ld = ($urandom_range(99) < 3);
            st = ($urandom_range(99) < 20);
            sp = ($urandom_range(99) < 4);
            lv = ND*4'($urandom);
            if ($urandom_range(3) == 0) lv = lv & 8'h0F;
            cycle("rnd", ld, lv, st, sp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
